id_ex_stage: RTL and testbench

- ID/EX pipeline register for the 5-stage MIPS pipeline.
- Captures decoded operands, immediate, register addresses and control bits from the ID stage.
- Presents them to EX. ex_read_data2 and ex_imm feed the ALU-source 2:1 mux, and ex_alu_src drives that mux's select.
- Contains load-use hazard detection. It inserts bubbles and drives stall_out to freeze PC and IF/ID.
- Contains a saturating stall-cycle counter for performance checks.

---
 rtl/id_ex_stage.sv | 118 +++++++++++
 tb/tb_id_ex_stage.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection and a saturating stall counter.
// EX sees either the captured ID instruction or a fully zeroed bubble. No ID data reaches EX combinationally.
module id_ex_stage #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int ALUOP_W    = 4,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  flush,
    input  logic                  id_valid,
    input  logic [DATA_W-1:0]     id_read_data1,
    input  logic [DATA_W-1:0]     id_read_data2,
    input  logic [DATA_W-1:0]     id_imm,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  id_uses_rt,
    input  logic                  id_reg_dst,
    input  logic                  id_alu_src,
    input  logic                  id_mem_read,
    input  logic                  id_mem_write,
    input  logic                  id_reg_write,
    input  logic                  id_mem_to_reg,
    input  logic [ALUOP_W-1:0]    id_alu_op,
    output logic [DATA_W-1:0]     ex_read_data1,
    output logic [DATA_W-1:0]     ex_read_data2,
    output logic [DATA_W-1:0]     ex_imm,
    output logic [REG_ADDR_W-1:0] ex_rs,
    output logic [REG_ADDR_W-1:0] ex_rt,
    output logic [REG_ADDR_W-1:0] ex_rd,
    output logic                  ex_reg_dst,
    output logic                  ex_alu_src,
    output logic                  ex_mem_read,
    output logic                  ex_mem_write,
    output logic                  ex_reg_write,
    output logic                  ex_mem_to_reg,
    output logic [ALUOP_W-1:0]    ex_alu_op,
    output logic                  ex_valid,
    output logic                  stall_out,
    output logic [CNT_W-1:0]      stall_count
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic rs_match;
    logic rt_match;
    logic hazard;
    logic load;

    // $0 is hard-wired zero, so a load targeting it never creates a dependency.
    assign rs_match  = (ex_rt == id_rs);
    assign rt_match  = id_uses_rt & (ex_rt == id_rt);
    assign hazard    = ex_valid & ex_mem_read & (ex_rt != '0) & id_valid & (rs_match | rt_match);
    assign stall_out = hazard & ~flush;
    assign load      = ~flush & ~hazard & id_valid;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ex_read_data1 <= '0;
            ex_read_data2 <= '0;
            ex_imm        <= '0;
            ex_rs         <= '0;
            ex_rt         <= '0;
            ex_rd         <= '0;
            ex_reg_dst    <= 1'b0;
            ex_alu_src    <= 1'b0;
            ex_mem_read   <= 1'b0;
            ex_mem_write  <= 1'b0;
            ex_reg_write  <= 1'b0;
            ex_mem_to_reg <= 1'b0;
            ex_alu_op     <= '0;
            ex_valid      <= 1'b0;
        end else if (load) begin
            ex_read_data1 <= id_read_data1;
            ex_read_data2 <= id_read_data2;
            ex_imm        <= id_imm;
            ex_rs         <= id_rs;
            ex_rt         <= id_rt;
            ex_rd         <= id_rd;
            ex_reg_dst    <= id_reg_dst;
            ex_alu_src    <= id_alu_src;
            ex_mem_read   <= id_mem_read;
            ex_mem_write  <= id_mem_write;
            ex_reg_write  <= id_reg_write;
            ex_mem_to_reg <= id_mem_to_reg;
            ex_alu_op     <= id_alu_op;
            ex_valid      <= 1'b1;
        end else begin
            // Bubble: everything zeroed so EX sees a deterministic no-op.
            ex_read_data1 <= '0;
            ex_read_data2 <= '0;
            ex_imm        <= '0;
            ex_rs         <= '0;
            ex_rt         <= '0;
            ex_rd         <= '0;
            ex_reg_dst    <= 1'b0;
            ex_alu_src    <= 1'b0;
            ex_mem_read   <= 1'b0;
            ex_mem_write  <= 1'b0;
            ex_reg_write  <= 1'b0;
            ex_mem_to_reg <= 1'b0;
            ex_alu_op     <= '0;
            ex_valid      <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_count <= '0;
        end else if (stall_out && (stall_count != CNT_MAX)) begin
            stall_count <= stall_count + CNT_ONE;
        end
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: pass-through, load-use stall, $0, flush priority, async reset, saturation.
// Built with a 4-bit stall counter so saturation is reachable with a short stimulus.
module tb_id_ex_stage;

    localparam int DATA_W     = 32;
    localparam int REG_ADDR_W = 5;
    localparam int ALUOP_W    = 4;
    localparam int CNT_W      = 4;

    logic                  clk = 1'b0;
    logic                  reset_n;
    logic                  flush;
    logic                  id_valid;
    logic [DATA_W-1:0]     id_read_data1, id_read_data2, id_imm;
    logic [REG_ADDR_W-1:0] id_rs, id_rt, id_rd;
    logic                  id_uses_rt;
    logic                  id_reg_dst, id_alu_src, id_mem_read, id_mem_write, id_reg_write, id_mem_to_reg;
    logic [ALUOP_W-1:0]    id_alu_op;
    logic [DATA_W-1:0]     ex_read_data1, ex_read_data2, ex_imm;
    logic [REG_ADDR_W-1:0] ex_rs, ex_rt, ex_rd;
    logic                  ex_reg_dst, ex_alu_src, ex_mem_read, ex_mem_write, ex_reg_write, ex_mem_to_reg;
    logic [ALUOP_W-1:0]    ex_alu_op;
    logic                  ex_valid;
    logic                  stall_out;
    logic [CNT_W-1:0]      stall_count;

    int checks = 0;
    int errors = 0;

    id_ex_stage #(
        .DATA_W(DATA_W), .REG_ADDR_W(REG_ADDR_W), .ALUOP_W(ALUOP_W), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset_n(reset_n), .flush(flush), .id_valid(id_valid),
        .id_read_data1(id_read_data1), .id_read_data2(id_read_data2), .id_imm(id_imm),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_uses_rt(id_uses_rt),
        .id_reg_dst(id_reg_dst), .id_alu_src(id_alu_src), .id_mem_read(id_mem_read),
        .id_mem_write(id_mem_write), .id_reg_write(id_reg_write), .id_mem_to_reg(id_mem_to_reg),
        .id_alu_op(id_alu_op),
        .ex_read_data1(ex_read_data1), .ex_read_data2(ex_read_data2), .ex_imm(ex_imm),
        .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
        .ex_reg_dst(ex_reg_dst), .ex_alu_src(ex_alu_src), .ex_mem_read(ex_mem_read),
        .ex_mem_write(ex_mem_write), .ex_reg_write(ex_reg_write), .ex_mem_to_reg(ex_mem_to_reg),
        .ex_alu_op(ex_alu_op), .ex_valid(ex_valid),
        .stall_out(stall_out), .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_id();
        flush = 1'b0; id_valid = 1'b0;
        id_read_data1 = '0; id_read_data2 = '0; id_imm = '0;
        id_rs = '0; id_rt = '0; id_rd = '0; id_uses_rt = 1'b0;
        id_reg_dst = 1'b0; id_alu_src = 1'b0; id_mem_read = 1'b0; id_mem_write = 1'b0;
        id_reg_write = 1'b0; id_mem_to_reg = 1'b0; id_alu_op = '0;
    endtask

    // lw $rt, 4($29)
    task automatic drive_lw(input logic [4:0] rt);
        clear_id();
        id_valid = 1'b1; id_mem_read = 1'b1; id_mem_to_reg = 1'b1; id_reg_write = 1'b1;
        id_alu_src = 1'b1; id_rs = 5'd29; id_rt = rt; id_imm = 32'd4;
    endtask

    // R-type add $rd, $rs, $rt
    task automatic drive_add(input logic [4:0] rs, input logic [4:0] rt, input logic uses_rt);
        clear_id();
        id_valid = 1'b1; id_rs = rs; id_rt = rt; id_rd = 5'd10; id_uses_rt = uses_rt;
        id_reg_dst = 1'b1; id_reg_write = 1'b1; id_alu_op = 4'd1; id_read_data1 = 32'h11;
    endtask

    initial begin
        clear_id();
        reset_n = 1'b0;
        tick(); tick();
        check("rst_ex_valid", 32'(ex_valid), 32'd0);
        check("rst_stall_count", 32'(stall_count), 32'd0);
        check("rst_stall_out", 32'(stall_out), 32'd0);
        reset_n = 1'b1;

        // Plain pass-through
        clear_id();
        id_valid = 1'b1; id_read_data1 = 32'd30; id_read_data2 = 32'd0; id_imm = 32'hFFFF_FFFC;
        id_alu_src = 1'b1; id_reg_write = 1'b1; id_alu_op = 4'd2;
        #1;
        check("pt_stall_pre", 32'(stall_out), 32'd0);
        tick();
        check("pt_data1", ex_read_data1, 32'd30);
        check("pt_data2", ex_read_data2, 32'd0);
        check("pt_imm", ex_imm, 32'hFFFF_FFFC);
        check("pt_alu_src", 32'(ex_alu_src), 32'd1);
        check("pt_alu_op", 32'(ex_alu_op), 32'd2);
        check("pt_valid", 32'(ex_valid), 32'd1);
        check("pt_stall_post", 32'(stall_out), 32'd0);

        // Load-use on rs
        drive_lw(5'd8);
        tick();
        check("lu_lw_mem_read", 32'(ex_mem_read), 32'd1);
        check("lu_lw_rt", 32'(ex_rt), 32'd8);
        drive_add(5'd8, 5'd9, 1'b1);
        #1;
        check("lu_stall_on", 32'(stall_out), 32'd1);
        tick();
        check("lu_bubble_valid", 32'(ex_valid), 32'd0);
        check("lu_bubble_regwr", 32'(ex_reg_write), 32'd0);
        check("lu_bubble_memrd", 32'(ex_mem_read), 32'd0);
        check("lu_count1", 32'(stall_count), 32'd1);
        check("lu_stall_off", 32'(stall_out), 32'd0);
        tick();
        check("lu_add_valid", 32'(ex_valid), 32'd1);
        check("lu_add_rs", 32'(ex_rs), 32'd8);
        check("lu_add_rd", 32'(ex_rd), 32'd10);
        check("lu_add_data1", ex_read_data1, 32'h11);
        check("lu_count_hold", 32'(stall_count), 32'd1);

        // rt matches but instruction does not read rt
        drive_lw(5'd8);
        tick();
        drive_add(5'd3, 5'd8, 1'b0);
        #1;
        check("nort_stall", 32'(stall_out), 32'd0);
        tick();
        check("nort_valid", 32'(ex_valid), 32'd1);
        check("nort_rt", 32'(ex_rt), 32'd8);
        check("nort_count", 32'(stall_count), 32'd1);

        // rt match with rt used
        drive_lw(5'd8);
        tick();
        drive_add(5'd3, 5'd8, 1'b1);
        #1;
        check("rt_stall", 32'(stall_out), 32'd1);
        tick();
        check("rt_bubble", 32'(ex_valid), 32'd0);
        check("rt_count", 32'(stall_count), 32'd2);
        tick();
        check("rt_add_valid", 32'(ex_valid), 32'd1);

        // Load to $0 never stalls
        drive_lw(5'd0);
        tick();
        check("r0_lw_memrd", 32'(ex_mem_read), 32'd1);
        drive_add(5'd0, 5'd0, 1'b1);
        #1;
        check("r0_stall", 32'(stall_out), 32'd0);
        tick();
        check("r0_valid", 32'(ex_valid), 32'd1);
        check("r0_count", 32'(stall_count), 32'd2);

        // Invalid ID slot: no stall, bubble
        drive_lw(5'd8);
        tick();
        drive_add(5'd8, 5'd9, 1'b1);
        id_valid = 1'b0;
        #1;
        check("inv_stall", 32'(stall_out), 32'd0);
        tick();
        check("inv_valid", 32'(ex_valid), 32'd0);
        check("inv_count", 32'(stall_count), 32'd2);

        // Flush beats hazard
        drive_lw(5'd8);
        tick();
        drive_add(5'd8, 5'd9, 1'b1);
        flush = 1'b1;
        #1;
        check("fl_stall", 32'(stall_out), 32'd0);
        tick();
        check("fl_valid", 32'(ex_valid), 32'd0);
        check("fl_rd", 32'(ex_rd), 32'd0);
        check("fl_count", 32'(stall_count), 32'd2);
        clear_id();
        id_valid = 1'b1; id_rs = 5'd5; id_rd = 5'd7; id_reg_write = 1'b1;
        tick();
        check("fl_next_valid", 32'(ex_valid), 32'd1);
        check("fl_next_rd", 32'(ex_rd), 32'd7);
        check("fl_next_count", 32'(stall_count), 32'd2);

        // Async reset asserted mid-stall
        drive_lw(5'd8);
        tick();
        drive_add(5'd8, 5'd9, 1'b1);
        #1;
        check("mr_stall_pre", 32'(stall_out), 32'd1);
        #1;
        reset_n = 1'b0;
        #1;
        check("mr_valid", 32'(ex_valid), 32'd0);
        check("mr_memrd", 32'(ex_mem_read), 32'd0);
        check("mr_rt", 32'(ex_rt), 32'd0);
        check("mr_imm", ex_imm, 32'd0);
        check("mr_count", 32'(stall_count), 32'd0);
        check("mr_stall", 32'(stall_out), 32'd0);
        #1;
        reset_n = 1'b1;
        tick();
        check("mr_after_valid", 32'(ex_valid), 32'd1);

        // Saturation: 20 load-use stalls into a 4-bit counter
        for (int i = 0; i < 20; i++) begin
            drive_lw(5'd8);
            tick();
            drive_add(5'd8, 5'd9, 1'b1);
            tick();
            check($sformatf("sat_%0d", i), 32'(stall_count), (i + 1 > 15) ? 32'd15 : 32'(i + 1));
        end
        tick();
        check("sat_final", 32'(stall_count), 32'd15);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
